// File: rtl/rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// rf_writeback_arbiter
//
// Producer side of the register file write port. ALU results and memory (load)
// results share the single registered (wen, wa, wd) write interface.
//
//   - ALU results always win the port and are never backpressured.
//   - Memory results go into a DEPTH-entry FIFO. The FIFO is drained only in
//     cycles where the ALU does not take the port.
//   - An ALU write is younger than everything queued. It therefore kills
//     ("squashes") any queued entry that targets the same register, and it
//     drops a same-cycle memory result to that register.
//   - A squashed entry keeps its FIFO slot. When it reaches the head it
//     produces an empty write slot (wen_o = 0).
//   - Register 0 is hardwired zero, so writes to it are discarded.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset_i      in   1      synchronous, active-high reset
//   alu_v_i      in   1      ALU result valid (always accepted)
//   alu_wa_i     in   A      ALU destination register
//   alu_wd_i     in   W      ALU result data
//   mem_v_i      in   1      memory result valid (transfers on mem_v_i & mem_ready_o)
//   mem_wa_i     in   A      memory destination register
//   mem_wd_i     in   W      memory result data
//   mem_ready_o  out  1      FIFO has a free slot
//   wen_o        out  1      register file write enable (registered)
//   wa_o         out  A      register file write address (registered)
//   wd_o         out  W      register file write data (registered)
//   pending_o    out  N      bit k set: a live queued entry targets register k
//   count_o      out  CW     occupied FIFO slots, squashed entries included
// ---------------------------------------------------------------------------
module rf_writeback_arbiter #(
    parameter int unsigned W     = 16,
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned A    = $clog2(N),
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          alu_v_i,
    input  logic [A-1:0]  alu_wa_i,
    input  logic [W-1:0]  alu_wd_i,
    input  logic          mem_v_i,
    input  logic [A-1:0]  mem_wa_i,
    input  logic [W-1:0]  mem_wd_i,
    output logic          mem_ready_o,
    output logic          wen_o,
    output logic [A-1:0]  wa_o,
    output logic [W-1:0]  wd_o,
    output logic [N-1:0]  pending_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ONE_C = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [A-1:0]  REG_ZERO_C = {A{1'b0}};

    // FIFO storage. Payload slots are written only on push and need no reset.
    // The live bits carry the state that matters.
    logic [A-1:0]     fifo_wa_r [DEPTH];
    logic [W-1:0]     fifo_wd_r [DEPTH];
    logic [DEPTH-1:0] fifo_live_r;
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;

    // Registered write port.
    logic             wen_r;
    logic [A-1:0]     wa_r;
    logic [W-1:0]     wd_r;

    // Per-cycle decisions.
    logic             alu_acc_s;
    logic             fifo_empty_s;
    logic             mem_ready_s;
    logic             pop_s;
    logic             push_s;
    logic [DEPTH-1:0] live_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic             wen_nxt_s;
    logic [A-1:0]     wa_nxt_s;
    logic [W-1:0]     wd_nxt_s;
    logic [N-1:0]     pending_s;

    // The ready signal depends only on registered occupancy. A pop in the same
    // cycle cannot open a slot early.
    assign mem_ready_s = (count_r < DEPTH_C);

    // Arbitration: the ALU owns the port, and the FIFO pops only when the ALU
    // does not write. A memory push to the register the ALU writes this cycle is
    // dropped, because the ALU value is the younger one.
    always_comb begin
        alu_acc_s    = alu_v_i && (alu_wa_i != REG_ZERO_C);
        fifo_empty_s = (count_r == {CW{1'b0}});
        pop_s        = !alu_acc_s && !fifo_empty_s;
        push_s       = mem_v_i && mem_ready_s && (mem_wa_i != REG_ZERO_C) &&
                       !(alu_acc_s && (mem_wa_i == alu_wa_i));
    end

    // Next live vector: squash matching entries, retire the head, then mark the
    // new tail. Pop and squash never coincide, because a pop needs the ALU to
    // be idle. Push and pop never hit the same slot (full blocks push, empty
    // blocks pop).
    always_comb begin
        live_nxt_s = fifo_live_r;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (alu_acc_s && (fifo_wa_r[i] == alu_wa_i)) begin
                live_nxt_s[i] = 1'b0;
            end else begin
                live_nxt_s[i] = live_nxt_s[i];
            end
        end
        if (pop_s) begin
            live_nxt_s[head_r] = 1'b0;
        end else begin
            live_nxt_s = live_nxt_s;
        end
        if (push_s) begin
            live_nxt_s[tail_r] = 1'b1;
        end else begin
            live_nxt_s = live_nxt_s;
        end
    end

    // Occupancy update.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Write-port selection. A squashed head gives an empty slot. The address and
    // data hold whenever nothing is written.
    always_comb begin
        wen_nxt_s = 1'b0;
        wa_nxt_s  = wa_r;
        wd_nxt_s  = wd_r;
        if (alu_acc_s) begin
            wen_nxt_s = 1'b1;
            wa_nxt_s  = alu_wa_i;
            wd_nxt_s  = alu_wd_i;
        end else if (pop_s) begin
            wen_nxt_s = fifo_live_r[head_r];
            if (fifo_live_r[head_r]) begin
                wa_nxt_s = fifo_wa_r[head_r];
                wd_nxt_s = fifo_wd_r[head_r];
            end else begin
                wa_nxt_s = wa_r;
                wd_nxt_s = wd_r;
            end
        end else begin
            wen_nxt_s = 1'b0;
        end
    end

    // Hazard vector for decode, taken from the registered live entries only.
    always_comb begin
        pending_s = {N{1'b0}};
        for (int i = 0; i < int'(DEPTH); i++) begin
            pending_s[fifo_wa_r[i]] = pending_s[fifo_wa_r[i]] | fifo_live_r[i];
        end
    end

    // Control state and the write-port registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            fifo_live_r <= {DEPTH{1'b0}};
            head_r      <= {PW{1'b0}};
            tail_r      <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            wen_r       <= 1'b0;
            wa_r        <= REG_ZERO_C;
            wd_r        <= {W{1'b0}};
        end else begin
            fifo_live_r <= live_nxt_s;
            count_r     <= count_nxt_s;
            wen_r       <= wen_nxt_s;
            wa_r        <= wa_nxt_s;
            wd_r        <= wd_nxt_s;
            if (pop_s) begin
                head_r <= head_r + PTR_ONE_C;
            end
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE_C;
            end
        end
    end

    // FIFO payload write at the tail.
    always_ff @(posedge clk) begin
        if (push_s && !reset_i) begin
            fifo_wa_r[tail_r] <= mem_wa_i;
            fifo_wd_r[tail_r] <= mem_wd_i;
        end
    end

    assign mem_ready_o = mem_ready_s;
    assign wen_o       = wen_r;
    assign wa_o        = wa_r;
    assign wd_o        = wd_r;
    assign pending_o   = pending_s;
    assign count_o     = count_r;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_arbiter
//
// Directed vector table for the documented corner cases, followed by a
// randomized run. The randomized run is compared against a queue-based
// reference model of the write-back rules.
// ---------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

    localparam int W     = 16;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int A     = 3;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          alu_v_i = 1'b0;
    logic [A-1:0]  alu_wa_i = '0;
    logic [W-1:0]  alu_wd_i = '0;
    logic          mem_v_i = 1'b0;
    logic [A-1:0]  mem_wa_i = '0;
    logic [W-1:0]  mem_wd_i = '0;
    logic          mem_ready_o;
    logic          wen_o;
    logic [A-1:0]  wa_o;
    logic [W-1:0]  wd_o;
    logic [N-1:0]  pending_o;
    logic [CW-1:0] count_o;

    always #5 clk = ~clk;

    rf_writeback_arbiter #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .alu_v_i     (alu_v_i),
        .alu_wa_i    (alu_wa_i),
        .alu_wd_i    (alu_wd_i),
        .mem_v_i     (mem_v_i),
        .mem_wa_i    (mem_wa_i),
        .mem_wd_i    (mem_wd_i),
        .mem_ready_o (mem_ready_o),
        .wen_o       (wen_o),
        .wa_o        (wa_o),
        .wd_o        (wd_o),
        .pending_o   (pending_o),
        .count_o     (count_o)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [A-1:0] wa;
        logic [W-1:0] wd;
        bit           live;
    } ent_t;

    ent_t         q[$];
    logic         m_wen = 1'b0;
    logic [A-1:0] m_wa  = '0;
    logic [W-1:0] m_wd  = '0;
    bit           m_rst = 1'b0;

    // Apply one clock of the write-back rules to the model, using the inputs
    // currently driven.
    task automatic model_step();
        bit   alu_acc;
        bit   rdy;
        ent_t e;
        if (reset_i) begin
            q.delete();
            m_wen = 1'b0;
            m_wa  = '0;
            m_wd  = '0;
            m_rst = 1'b1;
            return;
        end
        m_rst   = 1'b0;
        alu_acc = alu_v_i && (alu_wa_i != 0);
        rdy     = (q.size() < DEPTH);
        for (int i = 0; i < q.size(); i++) begin
            if (alu_acc && q[i].wa == alu_wa_i) begin
                e = q[i];
                e.live = 1'b0;
                q[i] = e;
            end
        end
        m_wen = 1'b0;
        if (alu_acc) begin
            m_wen = 1'b1;
            m_wa  = alu_wa_i;
            m_wd  = alu_wd_i;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.live) begin
                m_wen = 1'b1;
                m_wa  = e.wa;
                m_wd  = e.wd;
            end
        end
        if (mem_v_i && rdy && mem_wa_i != 0 && !(alu_acc && mem_wa_i == alu_wa_i)) begin
            e.wa = mem_wa_i;
            e.wd = mem_wd_i;
            e.live = 1'b1;
            q.push_back(e);
        end
    endtask

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] p = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].live) p[q[i].wa] = 1'b1;
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and sample 1 time unit
    // after the edge.
    task automatic drive(input bit rst, input bit av, input logic [A-1:0] awa,
                         input logic [W-1:0] awd, input bit mv,
                         input logic [A-1:0] mwa, input logic [W-1:0] mwd);
        reset_i  = rst;
        alu_v_i  = av;
        alu_wa_i = awa;
        alu_wd_i = awd;
        mem_v_i  = mv;
        mem_wa_i = mwa;
        mem_wd_i = mwd;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           rst;
        bit           av;
        logic [A-1:0] awa;
        logic [W-1:0] awd;
        bit           mv;
        logic [A-1:0] mwa;
        logic [W-1:0] mwd;
        bit           ewen;
        logic [A-1:0] ewa;
        logic [W-1:0] ewd;
        int           ecnt;
        logic [N-1:0] epend;
        bit           erdy;
        bit           chk;    // compare wa/wd as well
    } vec_t;

    vec_t vecs[$];

    task automatic v(input bit rst, input bit av, input logic [A-1:0] awa,
                     input logic [W-1:0] awd, input bit mv, input logic [A-1:0] mwa,
                     input logic [W-1:0] mwd, input bit ewen, input logic [A-1:0] ewa,
                     input logic [W-1:0] ewd, input int ecnt, input logic [N-1:0] epend,
                     input bit erdy, input bit chk);
        vec_t r;
        r.rst = rst; r.av = av; r.awa = awa; r.awd = awd;
        r.mv = mv; r.mwa = mwa; r.mwd = mwd;
        r.ewen = ewen; r.ewa = ewa; r.ewd = ewd; r.ecnt = ecnt;
        r.epend = epend; r.erdy = erdy; r.chk = chk;
        vecs.push_back(r);
    endtask

    initial begin
        // T1: reset, then a single ALU write
        v(1, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 1, 1);
        v(0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 1, 3'd3, 16'h1234, 0, 8'h00, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd3, 16'h1234, 0, 8'h00, 1, 1);
        // T2: ALU busy on r1 while five memory results arrive; the fifth is refused
        v(0, 1, 3'd1, 16'h0101, 1, 3'd2, 16'h2222, 1, 3'd1, 16'h0101, 1, 8'h04, 1, 1);
        v(0, 1, 3'd1, 16'h0102, 1, 3'd3, 16'h3333, 1, 3'd1, 16'h0102, 2, 8'h0C, 1, 1);
        v(0, 1, 3'd1, 16'h0103, 1, 3'd4, 16'h4444, 1, 3'd1, 16'h0103, 3, 8'h1C, 1, 1);
        v(0, 1, 3'd1, 16'h0104, 1, 3'd5, 16'h5555, 1, 3'd1, 16'h0104, 4, 8'h3C, 0, 1);
        v(0, 1, 3'd1, 16'h0105, 1, 3'd6, 16'h6666, 1, 3'd1, 16'h0105, 4, 8'h3C, 0, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd2, 16'h2222, 3, 8'h38, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd3, 16'h3333, 2, 8'h30, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd4, 16'h4444, 1, 8'h20, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd5, 16'h5555, 0, 8'h00, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd5, 16'h5555, 0, 8'h00, 1, 1);
        // T3: register 0 on either side is discarded
        v(0, 1, 3'd0, 16'hBEEF, 0, 3'd0, 16'h0000, 0, 3'd5, 16'h5555, 0, 8'h00, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 1, 3'd0, 16'hFFFF, 0, 3'd5, 16'h5555, 0, 8'h00, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd5, 16'h5555, 0, 8'h00, 1, 1);
        // T4: a younger ALU write squashes a queued entry
        v(0, 1, 3'd1, 16'h0201, 1, 3'd5, 16'h5555, 1, 3'd1, 16'h0201, 1, 8'h20, 1, 1);
        v(0, 1, 3'd5, 16'hAAAA, 0, 3'd0, 16'h0000, 1, 3'd5, 16'hAAAA, 1, 8'h00, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd5, 16'hAAAA, 0, 8'h00, 1, 0);
        // T5: same-cycle memory and ALU results to one register
        v(0, 1, 3'd2, 16'h0002, 1, 3'd2, 16'h0001, 1, 3'd2, 16'h0002, 0, 8'h00, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd2, 16'h0002, 0, 8'h00, 1, 1);
        // T6: reset in the middle of a drain
        v(0, 1, 3'd1, 16'h0301, 1, 3'd3, 16'h0033, 1, 3'd1, 16'h0301, 1, 8'h08, 1, 1);
        v(0, 1, 3'd1, 16'h0302, 1, 3'd4, 16'h0044, 1, 3'd1, 16'h0302, 2, 8'h18, 1, 1);
        v(0, 1, 3'd1, 16'h0303, 1, 3'd6, 16'h0066, 1, 3'd1, 16'h0303, 3, 8'h58, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd3, 16'h0033, 2, 8'h50, 1, 1);
        v(1, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 1, 1);
        v(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 1, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].av, vecs[k].awa, vecs[k].awd,
                  vecs[k].mv, vecs[k].mwa, vecs[k].mwd);
            check($sformatf("vec%0d wen", k), 32'(wen_o), 32'(vecs[k].ewen));
            check($sformatf("vec%0d count", k), 32'(count_o), 32'(vecs[k].ecnt));
            check($sformatf("vec%0d pending", k), 32'(pending_o), 32'(vecs[k].epend));
            check($sformatf("vec%0d ready", k), 32'(mem_ready_o), 32'(vecs[k].erdy));
            if (vecs[k].chk) begin
                check($sformatf("vec%0d wa", k), 32'(wa_o), 32'(vecs[k].ewa));
                check($sformatf("vec%0d wd", k), 32'(wd_o), 32'(vecs[k].ewd));
            end
        end

        // ---------------- randomized run against the model ----------------
        drive(1, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
        for (int c = 0; c < 3000; c++) begin
            int   alu_pct;
            bit   rst;
            bit   av;
            bit   mv;
            alu_pct = 30 + 30 * ((c / 200) % 3);
            rst = ($urandom_range(0, 199) == 0);
            av  = ($urandom_range(0, 99) < alu_pct);
            mv  = ($urandom_range(0, 99) < 60);
            drive(rst, av, A'($urandom_range(0, N - 1)), W'($urandom),
                  mv, A'($urandom_range(0, N - 1)), W'($urandom));
            check("rand wen", 32'(wen_o), 32'(m_wen));
            check("rand count", 32'(count_o), 32'(q.size()));
            check("rand pending", 32'(pending_o), 32'(model_pending()));
            check("rand ready", 32'(mem_ready_o), 32'(q.size() < DEPTH));
            if (m_wen || m_rst) begin
                check("rand wa", 32'(wa_o), 32'(m_wa));
                check("rand wd", 32'(wd_o), 32'(m_wd));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
